// File: rtl/lut3_sweep_ctrl_if.sv
// Host-side control bundle for lut3_sweep_ctrl: configuration write, sweep
// start/abort and the sweep result.
interface lut3_sweep_ctrl_if #(
   parameter int SETTLE_W = 8
);
   logic                cfg_valid;
   logic                cfg_ready;
   logic [7:0]          cfg_expect;
   logic [SETTLE_W-1:0] cfg_settle;
   logic                start;
   logic                abort;
   logic                busy;
   logic                done;
   logic                pass;
   logic [7:0]          captured;
   logic [7:0]          mismatch;

   modport master (
      output cfg_valid, cfg_expect, cfg_settle, start, abort,
      input  cfg_ready, busy, done, pass, captured, mismatch
   );

   modport slave (
      input  cfg_valid, cfg_expect, cfg_settle, start, abort,
      output cfg_ready, busy, done, pass, captured, mismatch
   );
endinterface

// File: rtl/lut3_sweep_ctrl.sv
// Exhaustive truth-table sweep of one 3-input logic block: drives rows 000..111,
// waits a programmable settle time per row, samples and compares the 8-bit code.
//
// state  | meaning
// IDLE   | accepting configuration, block inputs parked at 000
// SETTLE | driving current row, counting down settle cycles, sampling at zero
// DONE   | one-cycle completion pulse, pass/mismatch valid
module lut3_sweep_ctrl #(
   parameter int          SETTLE_W       = 8,
   parameter int unsigned DEFAULT_SETTLE = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   lut3_sweep_ctrl_if.slave      bus,
   output logic                  in1,
   output logic                  in2,
   output logic                  in3,
   input  logic                  dut_out
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          row_q, row_d;
   logic [SETTLE_W-1:0] cnt_q, cnt_d;
   logic [7:0]          expect_q, expect_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic [7:0]          captured_q, captured_d;
   logic                pass_q, pass_d;
   logic [7:0]          mismatch_q, mismatch_d;
   logic [7:0]          cap_upd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         row_q      <= 3'd0;
         cnt_q      <= '0;
         expect_q   <= 8'h00;
         settle_q   <= SETTLE_W'(DEFAULT_SETTLE);
         captured_q <= 8'h00;
         pass_q     <= 1'b0;
         mismatch_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         cnt_q      <= cnt_d;
         expect_q   <= expect_d;
         settle_q   <= settle_d;
         captured_q <= captured_d;
         pass_q     <= pass_d;
         mismatch_q <= mismatch_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      cnt_d      = cnt_q;
      expect_d   = expect_q;
      settle_d   = settle_q;
      captured_d = captured_q;
      pass_d     = pass_q;
      mismatch_d = mismatch_q;

      // Row 000 lands in the MSB, row 111 in the LSB.
      cap_upd               = captured_q;
      cap_upd[3'd7 - row_q] = dut_out;

      case (state_q)
         IDLE: begin
            if (bus.cfg_valid) begin
               expect_d = bus.cfg_expect;
               settle_d = bus.cfg_settle;
            end
            if (bus.start) begin
               row_d      = 3'd0;
               cnt_d      = bus.cfg_valid ? bus.cfg_settle : settle_q;
               captured_d = 8'h00;
               pass_d     = 1'b0;
               mismatch_d = 8'h00;
               state_d    = SETTLE;
            end
         end
         SETTLE: begin
            if (bus.abort) begin
               row_d      = 3'd0;
               cnt_d      = '0;
               pass_d     = 1'b0;
               mismatch_d = 8'h00;
               state_d    = IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               captured_d = cap_upd;
               if (row_q == 3'd7) begin
                  pass_d     = (cap_upd == expect_q);
                  mismatch_d = cap_upd ^ expect_q;
                  state_d    = DONE;
               end else begin
                  row_d = row_q + 3'd1;
                  cnt_d = settle_q;
               end
            end
         end
         DONE: begin
            row_d   = 3'd0;
            state_d = IDLE;
            if (bus.abort) begin
               pass_d     = 1'b0;
               mismatch_d = 8'h00;
            end
         end
         default: begin
            row_d   = 3'd0;
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Ready is held low while in reset so every output reads 0 during rst_n low.
   assign bus.cfg_ready = (state_q == IDLE) && rst_n;
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = (state_q == DONE);
   assign bus.pass      = pass_q;
   assign bus.captured  = captured_q;
   assign bus.mismatch  = mismatch_q;

   assign {in1, in2, in3} = (state_q != IDLE) ? row_q : 3'b000;

endmodule
